// File: rtl/stream_arbiter.sv
// stream_arbiter: four-way Avalon-ST packet arbiter onto one shared source.
// Arbitration is round-robin over requesters that present a start-of-packet
// beat. Grants happen on packet boundaries only. Granting costs one idle cycle,
// and the packet then streams through combinationally until its EOP beat is
// accepted. While idle, non-SOP beats are consumed, thrown away and flagged
// on orphan_err.
// Optional build macro STREAM_ARBITER_PKT_CNT_EN adds the pkt_cnt output. It
// holds four 16-bit wrapping counters of packets completed per requester.
module stream_arbiter #(
    parameter int DATA_WIDTH  = 64,
    parameter int EMPTY_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [4*DATA_WIDTH-1:0]    in_data,
    input  logic [3:0]                 in_valid,
    input  logic [3:0]                 in_sop,
    input  logic [3:0]                 in_eop,
    input  logic [4*EMPTY_WIDTH-1:0]   in_empty,
    output logic [3:0]                 in_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic [EMPTY_WIDTH-1:0]     out_empty,
    input  logic                       out_ready,
    input  logic [3:0]                 in_en,
    output logic                       busy,
    output logic [1:0]                 grant_idx,
    output logic                       orphan_err
`ifdef STREAM_ARBITER_PKT_CNT_EN
    ,
    output logic [63:0]                pkt_cnt
`endif
);

    typedef enum logic {IDLE, PASS} state_t;

    state_t     state;
    logic [1:0] last_grant;
    logic [3:0] cand;
    logic [3:0] discard;
    logic [1:0] sel;
    logic [1:0] idx;
    logic       sel_found;
    logic       pass;
    logic       done;

    assign pass    = (state == PASS);
    assign cand    = in_valid & in_sop & in_en;
    assign discard = in_valid & ~in_sop;

    // Round-robin pick: first candidate found searching upward from last_grant+1
    always_comb begin
        sel       = 2'd0;
        sel_found = 1'b0;
        idx       = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + 2'(k);
            if (!sel_found && cand[idx]) begin
                sel       = idx;
                sel_found = 1'b1;
            end
        end
    end

    // Source side follows the granted sink while a packet is in flight
    always_comb begin
        out_data  = in_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        out_empty = in_empty[grant_idx*EMPTY_WIDTH +: EMPTY_WIDTH];
        out_valid = pass & in_valid[grant_idx];
        out_sop   = pass & in_sop[grant_idx];
        out_eop   = pass & in_eop[grant_idx];
    end

    assign done = out_valid & out_ready & out_eop;

    // Ready steering: granted sink mirrors out_ready; idle drains orphan beats.
    // Held low during reset so no beat is taken while the arbiter is cleared.
    always_comb begin
        in_ready = 4'b0000;
        if (!rst_n) begin
            in_ready = 4'b0000;
        end else if (pass) begin
            in_ready[grant_idx] = out_ready;
        end else begin
            in_ready = discard;
        end
    end

    // Arbitration FSM with registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 2'd3;
            grant_idx  <= 2'd0;
            busy       <= 1'b0;
            orphan_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    orphan_err <= |discard;
                    if (sel_found) begin
                        state      <= PASS;
                        grant_idx  <= sel;
                        last_grant <= sel;
                        busy       <= 1'b1;
                    end
                end
                PASS: begin
                    orphan_err <= 1'b0;
                    if (done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    orphan_err <= 1'b0;
                end
            endcase
        end
    end

`ifdef STREAM_ARBITER_PKT_CNT_EN
    // Per-requester completed-packet counters, wrapping at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (done && grant_idx == 2'(i)) begin
                    pkt_cnt[i*16 +: 16] <= pkt_cnt[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter: reset, two-requester handoff, round-robin
// order, backpressure, orphan discard, enable masking and mid-packet reset.
module tb_stream_arbiter;

    localparam int DW = 64;
    localparam int EW = 3;

    logic              clk;
    logic              rst_n;
    logic [4*DW-1:0]   in_data;
    logic [3:0]        in_valid;
    logic [3:0]        in_sop;
    logic [3:0]        in_eop;
    logic [4*EW-1:0]   in_empty;
    logic [3:0]        in_ready;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_sop;
    logic              out_eop;
    logic [EW-1:0]     out_empty;
    logic              out_ready;
    logic [3:0]        in_en;
    logic              busy;
    logic [1:0]        grant_idx;
    logic              orphan_err;
`ifdef STREAM_ARBITER_PKT_CNT_EN
    logic [63:0]       pkt_cnt;
`endif

    int checks;
    int errors;
    int beat;

    stream_arbiter #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_empty   (in_empty),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_empty  (out_empty),
        .out_ready  (out_ready),
        .in_en      (in_en),
        .busy       (busy),
        .grant_idx  (grant_idx),
        .orphan_err (orphan_err)
`ifdef STREAM_ARBITER_PKT_CNT_EN
        ,
        .pkt_cnt    (pkt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic s, input logic e,
                           input logic [63:0] d);
        in_valid[i]         = v;
        in_sop[i]           = s;
        in_eop[i]           = e;
        in_data[i*DW +: DW] = d;
        in_empty[i*EW +: EW] = 3'(i);
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        in_data   = '0;
        in_empty  = '0;
        in_valid  = 4'b0000;
        in_sop    = 4'b0000;
        in_eop    = 4'b0000;
        in_en     = 4'b1111;
        out_ready = 1'b1;
        rst_n     = 1'b0;

        // Reset: orphan beats on every input must not be accepted
        in_valid = 4'b1111;
        settle();
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_grant", 64'(grant_idx), 64'h0);
        chk("rst_orphan", 64'(orphan_err), 64'h0);
        chk("rst_in_ready_held", 64'(in_ready), 64'h0);
        in_valid = 4'b0000;
        rst_n    = 1'b1;

        // Requesters 0 and 2 each send three beats
        set_req(0, 1, 1, 0, 64'h00);
        set_req(2, 1, 1, 0, 64'h20);
        settle();
        chk("s1_idle_valid", 64'(out_valid), 64'h0);
        chk("s1_idle_ready", 64'(in_ready), 64'h0);
        tick();
        chk("s1_busy", 64'(busy), 64'h1);
        chk("s1_grant0", 64'(grant_idx), 64'h0);
        chk("s1_b0_data", out_data, 64'h00);
        chk("s1_b0_sop", 64'(out_sop), 64'h1);
        chk("s1_b0_ready", 64'(in_ready), 64'h1);
        chk("s1_b0_empty", 64'(out_empty), 64'h0);
        tick();
        set_req(0, 1, 0, 0, 64'h01);
        settle();
        chk("s1_b1_data", out_data, 64'h01);
        tick();
        set_req(0, 1, 0, 1, 64'h02);
        settle();
        chk("s1_b2_data", out_data, 64'h02);
        chk("s1_b2_eop", 64'(out_eop), 64'h1);
        tick();
        set_req(0, 0, 0, 0, 64'h0);
        settle();
        chk("s1_bubble_busy", 64'(busy), 64'h0);
        chk("s1_bubble_valid", 64'(out_valid), 64'h0);
        chk("s1_bubble_ready", 64'(in_ready), 64'h0);
        tick();
        chk("s1_grant2", 64'(grant_idx), 64'h2);
        chk("s1_r2b0_data", out_data, 64'h20);
        chk("s1_r2b0_ready", 64'(in_ready), 64'h4);
        chk("s1_r2b0_empty", 64'(out_empty), 64'h2);
        tick();
        set_req(2, 1, 0, 0, 64'h21);
        settle();
        chk("s1_r2b1_data", out_data, 64'h21);
        tick();
        set_req(2, 1, 0, 1, 64'h22);
        settle();
        chk("s1_r2b2_data", out_data, 64'h22);
        tick();
        set_req(2, 0, 0, 0, 64'h0);
        settle();
        chk("s1_end_busy", 64'(busy), 64'h0);

        // Fresh reset, then all four send back-to-back single-beat packets
        rst_n = 1'b0;
        settle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1, 1, 1, 64'hB0 + 64'(i));
        for (int k = 0; k < 6; k++) begin
            settle();
            chk("s2_idle_valid", 64'(out_valid), 64'h0);
            chk("s2_idle_busy", 64'(busy), 64'h0);
            tick();
            chk("s2_grant", 64'(grant_idx), 64'(k % 4));
            chk("s2_data", out_data, 64'hB0 + 64'(k % 4));
            chk("s2_ready", 64'(in_ready), 64'(1 << (k % 4)));
            tick();
        end
        in_valid = 4'b0000;
        in_sop   = 4'b0000;
        in_eop   = 4'b0000;

        // Requester 1 sends four beats under alternating backpressure
        set_req(1, 1, 1, 0, 64'hA0);
        settle();
        tick();
        beat = 0;
        for (int c = 0; c < 7; c++) begin
            out_ready = (c % 2 == 0);
            settle();
            chk("s3_grant", 64'(grant_idx), 64'h1);
            chk("s3_data", out_data, 64'hA0 + 64'(beat));
            chk("s3_ready", 64'(in_ready), out_ready ? 64'h2 : 64'h0);
            tick();
            if (out_ready) begin
                beat++;
                if (beat < 4) set_req(1, 1, 0, (beat == 3), 64'hA0 + 64'(beat));
                else          set_req(1, 0, 0, 0, 64'h0);
            end
        end
        out_ready = 1'b1;
        settle();
        chk("s3_beats", 64'(beat), 64'h4);
        chk("s3_end_busy", 64'(busy), 64'h0);

        // Orphan beat from requester 3 while idle
        set_req(3, 1, 0, 0, 64'h33);
        settle();
        chk("s4_ready", 64'(in_ready), 64'h8);
        chk("s4_valid", 64'(out_valid), 64'h0);
        chk("s4_orphan_pre", 64'(orphan_err), 64'h0);
        tick();
        set_req(3, 0, 0, 0, 64'h0);
        settle();
        chk("s4_orphan", 64'(orphan_err), 64'h1);
        chk("s4_busy", 64'(busy), 64'h0);
        chk("s4_valid_after", 64'(out_valid), 64'h0);
        tick();
        chk("s4_orphan_clr", 64'(orphan_err), 64'h0);

        // Enable mask, mid-packet disable, then reset mid-packet
        in_en = 4'b1110;
        set_req(0, 1, 1, 1, 64'hD0);
        set_req(1, 1, 1, 0, 64'hC0);
        settle();
        chk("s5_idle_ready", 64'(in_ready), 64'h0);
        tick();
        chk("s5_grant1", 64'(grant_idx), 64'h1);
        chk("s5_b0_data", out_data, 64'hC0);
        tick();
        in_en = 4'b1100;
        set_req(1, 1, 0, 0, 64'hC1);
        settle();
        chk("s5_b1_busy", 64'(busy), 64'h1);
        chk("s5_b1_data", out_data, 64'hC1);
        chk("s5_b1_ready", 64'(in_ready), 64'h2);
        tick();
        set_req(1, 1, 0, 1, 64'hC2);
        settle();
        chk("s5_b2_data", out_data, 64'hC2);
        rst_n = 1'b0;
        settle();
        chk("s5_rst_valid", 64'(out_valid), 64'h0);
        chk("s5_rst_busy", 64'(busy), 64'h0);
        chk("s5_rst_ready", 64'(in_ready), 64'h0);
        chk("s5_rst_grant", 64'(grant_idx), 64'h0);
        rst_n = 1'b1;
        in_en = 4'b1111;
        set_req(1, 1, 1, 1, 64'hE0);
        settle();
        tick();
        chk("s5_post_grant0", 64'(grant_idx), 64'h0);
        chk("s5_post_data0", out_data, 64'hD0);
        tick();
        set_req(0, 0, 0, 0, 64'h0);
        settle();
        tick();
        chk("s5_post_grant1", 64'(grant_idx), 64'h1);
        chk("s5_post_data1", out_data, 64'hE0);
        tick();
        set_req(1, 0, 0, 0, 64'h0);
        settle();
        chk("s5_end_busy", 64'(busy), 64'h0);
`ifdef STREAM_ARBITER_PKT_CNT_EN
        chk("cnt_r0", 64'(pkt_cnt[15:0]), 64'h1);
        chk("cnt_r1", 64'(pkt_cnt[31:16]), 64'h1);
        chk("cnt_r2", 64'(pkt_cnt[47:32]), 64'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
